// File: rtl/sync_link_pkg.sv
// Shared types and helpers for the sync-to-async dual-rail link bridges.
package sync_link_pkg;

    localparam int unsigned RAIL_NUM = 2;

    // [1] true rail, [0] false rail
    typedef logic [RAIL_NUM-1:0] rail_pair_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET,
        ST_WAIT_HI,
        ST_RTZ,
        ST_WAIT_LO,
        ST_WAIT_ACK
    } link_state_t;

    function automatic rail_pair_t dr_encode(input logic b);
        return {b, ~b};
    endfunction

endpackage

// File: rtl/ack_sync.sv
// Multi-flop synchronizer for an asynchronous link acknowledge.
module ack_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ack_i,
    output logic ack_s
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[STAGES-2:0], ack_i};
    end

    assign ack_s = sync_q[STAGES-1];

endmodule

// File: rtl/sync_link_driver.sv
// Valid/ready to dual-rail link source, two-phase (TP) or four-phase RZ (FP).
// Optional ack timeout enabled by defining SYNC_LINK_DRV_TIMEOUT_EN.
module sync_link_driver
    import sync_link_pkg::*;
#(
    parameter string       ENC         = "TP",
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TMO_W       = 12
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [WIDTH-1:0]                 data_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    output logic [WIDTH-1:0][RAIL_NUM-1:0]   out,
    input  logic                             ack_i,
    output logic                             busy_o,
    output logic [CNT_W-1:0]                 cnt_o,
    output logic                             tmo_o
);

    link_state_t             state, nxt;
    rail_pair_t [WIDTH-1:0]  out_q, out_d;
    logic [CNT_W-1:0]        cnt_q;
    logic                    cnt_inc;
    logic                    ack_s;
    logic                    run_q;
    logic                    acc_ok;
    logic                    hs;
    logic                    tmo_hit;

    ack_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .rst   (rst),
        .ack_i (ack_i),
        .ack_s (ack_s)
    );

    // run_q keeps ready low while reset is applied and for the first edge after release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            out_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            state <= nxt;
            out_q <= out_d;
            run_q <= 1'b1;
            if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign ready_o = run_q && (state == ST_IDLE) && acc_ok;
    assign hs      = valid_i && ready_o;
    assign busy_o  = (state != ST_IDLE);
    assign out     = out_q;
    assign cnt_o   = cnt_q;

`ifdef SYNC_LINK_DRV_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_q;
    logic             in_wait;

    assign in_wait = state inside {ST_WAIT_ACK, ST_WAIT_HI, ST_WAIT_LO};
    assign tmo_hit = in_wait && (tmo_cnt == '1);
    assign tmo_o   = tmo_q;

    // Counts cycles spent in one wait state; any state change restarts it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
            tmo_q   <= 1'b0;
        end else begin
            if (!in_wait || (nxt != state)) tmo_cnt <= '0;
            else                             tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (tmo_hit) tmo_q <= 1'b1;
        end
    end
`else
    // Without the timeout the wait states hold until the ack arrives
    assign tmo_hit = 1'b0 & (TMO_W == 0);
    assign tmo_o   = 1'b0;
`endif

    if (ENC == "FP") begin : g_fp
        // A stale high ack in IDLE is a protocol error: hold off until it drops
        assign acc_ok = !ack_s;

        always_comb begin
            nxt     = state;
            out_d   = out_q;
            cnt_inc = 1'b0;
            case (state)
                ST_IDLE: begin
                    if (hs) begin
                        for (int unsigned b = 0; b < WIDTH; b++) out_d[b] = dr_encode(data_i[b]);
                        nxt = ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    if (ack_s) begin
                        out_d = '0;
                        nxt   = ST_WAIT_LO;
                    end else if (tmo_hit) begin
                        nxt = ST_IDLE;
                    end
                end
                ST_WAIT_LO: begin
                    if (!ack_s) begin
                        cnt_inc = 1'b1;
                        nxt     = ST_IDLE;
                    end else if (tmo_hit) begin
                        nxt = ST_IDLE;
                    end
                end
                // SET/RTZ are skew-delay placeholders, unreachable without a configured delay
                default: nxt = ST_IDLE;
            endcase
        end
    end else begin : g_tp
        logic exp_q, exp_d;

        assign acc_ok = 1'b1;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) exp_q <= 1'b0;
            else     exp_q <= exp_d;
        end

        always_comb begin
            nxt     = state;
            out_d   = out_q;
            exp_d   = exp_q;
            cnt_inc = 1'b0;
            case (state)
                ST_IDLE: begin
                    if (hs) begin
                        for (int unsigned b = 0; b < WIDTH; b++) begin
                            if (data_i[b]) out_d[b][1] = ~out_q[b][1];
                            else           out_d[b][0] = ~out_q[b][0];
                        end
                        nxt = ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (ack_s != exp_q) begin
                        exp_d   = ~exp_q;
                        cnt_inc = 1'b1;
                        nxt     = ST_IDLE;
                    end else if (tmo_hit) begin
                        nxt = ST_IDLE;
                    end
                end
                default: nxt = ST_IDLE;
            endcase
        end
    end

endmodule
